mem_ksa: RTL and testbench
==========================

Name: mem_ksa

Overview:
- RC4 key-scheduling stage (init + KSA) feeding mem_decrypt directly.
- On start_sig: fills S-RAM with s[i]=i, then runs the 256-iteration KSA swap loop using secret_key.
- Drives the shared S-RAM through the memory handler; its finish output is mem_decrypt's start_sig.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte index = i mod KEY_BYTES.
- KEY_WIDTH, 8*KEY_BYTES, width of secret_key.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_sig  in  1  level start request, sampled in IDLE only
- abort  in  1  synchronous abort (another core found the key)
- secret_key  in  KEY_WIDTH  key; byte 0 = secret_key[KEY_WIDTH-1 -: 8], MSB-first
- q_data  in  8  S-RAM read data
- finish  out  1  high while in DONE
- ksa_mem_handler  out  1  requests S-RAM ownership from the handler mux; high in every state except IDLE and DONE
- memory_sel  out  2  handler select: 1 (S-RAM) while owning, else 0
- address  out  8  S-RAM address
- data  out  8  S-RAM write data
- wen  out  1  S-RAM write enable

Behaviour:
- Output decode: all outputs are Moore decode of state plus registers i, j, temp_i, temp_j. A write commits on the clock edge that leaves a write state.
- Reset: reset_n low returns to IDLE immediately. i, j, key_idx, temp_i and temp_j clear to 0. All outputs are 0.
- RAM timing: address is held for SETUP and READ. q_data is captured on the edge leaving SAMPLE, which tolerates 2-cycle registered-output RAM.
- States and transitions:
  - IDLE: go to START if start_sig, else stay in IDLE.
  - START: clear i=0, j=0, key_idx=0; go to INIT.
  - INIT: address=i, data=i, wen=1. Increment i each cycle; i==255 writes, then i wraps to 0 and the state goes to SETUP_I.
  - SETUP_I, READ_I, SAMPLE_I: address=i; temp_i<=q_data on the edge leaving SAMPLE_I.
  - ADD_J: j <= j + temp_i + key[key_idx], all mod 256 (8-bit wrap, carries dropped).
  - SETUP_J, READ_J, SAMPLE_J: address=j; temp_j<=q_data.
  - WRITE_I: address=i, data=temp_j, wen=1.
  - WRITE_J: address=j, data=temp_i, wen=1.
  - INC_I: if i==255 go to DONE. Else i<=i+1, key_idx<=(key_idx==KEY_BYTES-1)?0:key_idx+1, then go to SETUP_I.
  - DONE: finish=1, ksa_mem_handler=0. Stay in DONE while start_sig is high; go to IDLE when start_sig is low.
- Latency: exactly 10 cycles per KSA iteration. If start_sig is sampled high at edge 0, finish is first high after edge 2817 (1 START + 256 INIT + 2560 KSA).
- Key indexing: key_idx is a counter, not a modulo operator.
- i==j: both writes target the same address. Final value is temp_i (the original s[i]), which is correct RC4.
- abort: from any state except IDLE/DONE, go to IDLE on the next edge. Any write whose state is current at that edge still commits; no further writes follow. finish stays 0 and counters clear in IDLE→START.
- start_sig: ignored outside IDLE/DONE.
- Reset mid-operation: immediate IDLE. S-RAM contents are undefined; the next start redoes the full init.

Decomposition:
- Shared package rc4_pkg holds:
  - RC4_N=256;
  - memory_sel encodings MEM_NONE=0, MEM_S=1, MEM_ENC=2, MEM_DEC=3;
  - typedef enum logic [3:0] ksa_state_t.
- Sub-module key_byte_sel (combinational): selects secret_key byte by key_idx, parameterised on KEY_BYTES. Keeps the main FSM free of the variable part-select.

Test Plan:
- Reset: reset_n=0 mid-INIT → same cycle all outputs 0; after release, state stays IDLE with start_sig=0.
- Init fill: start_sig=1, key=24'h000000 → edges 2..257 write address k, data k, wen=1, k=0..255; memory model then holds S[k]=k.
- i==j swap: key=24'h000000, iteration 0 → j=0; WRITE_I and WRITE_J both address 0, data 0; S[0] remains 0.
- Golden KSA: key=24'h00033C → finish first high exactly 2817 cycles after start sampled; final S-RAM equals software KSA for the same key, all 256 entries.
- Abort: assert abort during iteration 100 READ_J → next cycle wen=0, ksa_mem_handler=0, memory_sel=0. A new start restarts at INIT, and the result again matches golden.
- DONE handshake: hold start_sig high → finish stays 1 indefinitely; drop start_sig → next cycle finish=0 and state is IDLE.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: table size, handler select codes and KSA states.
package rc4_pkg;

  localparam int RC4_N = 256;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_S    = 2'd1;
  localparam logic [1:0] MEM_ENC  = 2'd2;
  localparam logic [1:0] MEM_DEC  = 2'd3;

  typedef enum logic [3:0] {
    KSA_IDLE,
    KSA_START,
    KSA_INIT,
    KSA_SETUP_I,
    KSA_READ_I,
    KSA_SAMPLE_I,
    KSA_ADD_J,
    KSA_SETUP_J,
    KSA_READ_J,
    KSA_SAMPLE_J,
    KSA_WRITE_I,
    KSA_WRITE_J,
    KSA_INC_I,
    KSA_DONE
  } ksa_state_t;

  // Width of a key byte counter; at least one bit even for a 1-byte key.
  function automatic int key_idx_width(int key_bytes);
    return (key_bytes > 1) ? $clog2(key_bytes) : 1;
  endfunction

endpackage

// File: rtl/mem_ksa_if.sv
// S-RAM bus between the KSA stage (master) and the memory handler (slave).
interface mem_ksa_if;
  logic [7:0] address;
  logic [7:0] data;
  logic       wen;
  logic [7:0] q_data;
  logic [1:0] memory_sel;
  logic       ksa_mem_handler;

  modport master (
    output address, data, wen, memory_sel, ksa_mem_handler,
    input  q_data
  );

  modport slave (
    input  address, data, wen, memory_sel, ksa_mem_handler,
    output q_data
  );
endinterface

// File: rtl/mem_ksa_key_byte_sel.sv
// Picks key byte key_idx out of secret_key; byte 0 is the most significant byte.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int KIDX_W    = key_idx_width(KEY_BYTES)
) (
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [KIDX_W-1:0]      key_idx,
  output logic [7:0]             key_byte
);

  // Decoded mux over the key bytes, no variable part-select needed.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (key_idx == KIDX_W'(b)) begin
        key_byte = 8'(secret_key >> (8 * (KEY_BYTES - 1 - b)));
      end
    end
  end

endmodule

// File: rtl/mem_ksa.sv
// RC4 key scheduling: fills S with the identity, then runs the 256-step swap loop.
// finish feeds the decrypt stage's start; the S-RAM is reached through the handler mux.
module mem_ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int KEY_WIDTH = 8 * KEY_BYTES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_sig,
  input  logic                 abort,
  input  logic [KEY_WIDTH-1:0] secret_key,
  output logic                 finish,
  mem_ksa_if.master            mem
);

  localparam int         KIDX_W = key_idx_width(KEY_BYTES);
  localparam logic [7:0] LAST_I = 8'(RC4_N - 1);

  ksa_state_t        state, state_next;
  logic [7:0]        i, j, temp_i, temp_j;
  logic [KIDX_W-1:0] key_idx;
  logic [7:0]        key_byte;
  logic              busy;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_sel (
    .secret_key (secret_key),
    .key_idx    (key_idx),
    .key_byte   (key_byte)
  );

  assign busy = (state != KSA_IDLE) && (state != KSA_DONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= KSA_IDLE;
    else          state <= state_next;
  end

  // Next-state sequencing; abort overrides everything while the stage is busy.
  always_comb begin
    state_next = state;
    case (state)
      KSA_IDLE:     if (start_sig) state_next = KSA_START;
      KSA_START:    state_next = KSA_INIT;
      KSA_INIT:     if (i == LAST_I) state_next = KSA_SETUP_I;
      KSA_SETUP_I:  state_next = KSA_READ_I;
      KSA_READ_I:   state_next = KSA_SAMPLE_I;
      KSA_SAMPLE_I: state_next = KSA_ADD_J;
      KSA_ADD_J:    state_next = KSA_SETUP_J;
      KSA_SETUP_J:  state_next = KSA_READ_J;
      KSA_READ_J:   state_next = KSA_SAMPLE_J;
      KSA_SAMPLE_J: state_next = KSA_WRITE_I;
      KSA_WRITE_I:  state_next = KSA_WRITE_J;
      KSA_WRITE_J:  state_next = KSA_INC_I;
      KSA_INC_I:    state_next = (i == LAST_I) ? KSA_DONE : KSA_SETUP_I;
      KSA_DONE:     if (!start_sig) state_next = KSA_IDLE;
      default:      state_next = KSA_IDLE;
    endcase
    if (abort && busy) state_next = KSA_IDLE;
  end

  // Moore bus decode; the RAM address stays stable across setup, read and sample.
  always_comb begin
    mem.address         = '0;
    mem.data            = '0;
    mem.wen             = 1'b0;
    mem.ksa_mem_handler = busy;
    mem.memory_sel      = busy ? MEM_S : MEM_NONE;
    finish              = 1'b0;
    case (state)
      KSA_INIT: begin
        mem.address = i;
        mem.data    = i;
        mem.wen     = 1'b1;
      end
      KSA_SETUP_I, KSA_READ_I, KSA_SAMPLE_I: mem.address = i;
      KSA_SETUP_J, KSA_READ_J, KSA_SAMPLE_J: mem.address = j;
      KSA_WRITE_I: begin
        mem.address = i;
        mem.data    = temp_j;
        mem.wen     = 1'b1;
      end
      KSA_WRITE_J: begin
        mem.address = j;
        mem.data    = temp_i;
        mem.wen     = 1'b1;
      end
      KSA_DONE: finish = 1'b1;
      default: ;
    endcase
  end

  // Index, accumulator and swap-operand registers; arithmetic wraps at 8 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i       <= '0;
      j       <= '0;
      key_idx <= '0;
      temp_i  <= '0;
      temp_j  <= '0;
    end else begin
      case (state)
        KSA_START: begin
          i       <= '0;
          j       <= '0;
          key_idx <= '0;
        end
        KSA_INIT:     i      <= i + 8'd1;
        KSA_SAMPLE_I: temp_i <= mem.q_data;
        KSA_ADD_J:    j      <= j + temp_i + key_byte;
        KSA_SAMPLE_J: temp_j <= mem.q_data;
        KSA_INC_I: begin
          if (i != LAST_I) begin
            i       <= i + 8'd1;
            key_idx <= (key_idx == KIDX_W'(KEY_BYTES - 1)) ? '0 : key_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ksa.sv
// Bench for mem_ksa: 2-cycle registered S-RAM model, software KSA reference,
// and a write-sequence scoreboard checked every cycle.
module tb_mem_ksa;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_sig;
  logic        abort;
  logic [23:0] secret_key;
  logic        finish;

  mem_ksa_if mem ();

  mem_ksa #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_sig  (start_sig),
    .abort      (abort),
    .secret_key (secret_key),
    .finish     (finish),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]  ram [256];
  logic [7:0]  addrQ;
  logic [7:0]  qReg;
  logic [7:0]  modelS [256];
  logic [15:0] expQ [$];
  logic [7:0]  logA [768];
  logic [7:0]  logD [768];
  int          writeCount = 0;

  assign mem.q_data = qReg;

  // S-RAM with registered address and registered output (2-cycle read).
  always @(posedge clk) begin
    if (mem.wen) ram[mem.address] <= mem.data;
    addrQ <= mem.address;
    qReg  <= ram[addrQ];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Software RC4 KSA; optionally queues every RAM write the hardware must make.
  function automatic void runModel(input logic [23:0] key, input int nIter, input bit genWrites);
    int jm;
    logic [7:0] kb, t;
    for (int k = 0; k < 256; k++) begin
      modelS[k] = 8'(k);
      if (genWrites) expQ.push_back({8'(k), 8'(k)});
    end
    jm = 0;
    for (int n = 0; n < nIter; n++) begin
      kb = 8'(key >> (8 * (2 - (n % 3))));
      jm = (jm + int'(modelS[n]) + int'(kb)) % 256;
      if (genWrites) begin
        expQ.push_back({8'(n), modelS[jm]});
        expQ.push_back({8'(jm), modelS[n]});
      end
      t = modelS[n];
      modelS[n] = modelS[jm];
      modelS[jm] = t;
    end
  endfunction

  // Every write the DUT makes must be the next one the reference predicts.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset_n === 1'b1) begin
      if (expQ.size() != 0) checkOutput("finish_before_all_writes", 32'(finish), 0);
      if (mem.wen) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("write_addr", 32'(mem.address), 32'(e[15:8]));
          checkOutput("write_data", 32'(mem.data), 32'(e[7:0]));
        end
        if (writeCount < 768) begin
          logA[writeCount] = mem.address;
          logD[writeCount] = mem.data;
        end
        writeCount++;
      end
    end
  end

  task automatic checkRam(input string name);
    for (int k = 0; k < 256; k++) checkOutput(name, 32'(ram[k]), 32'(modelS[k]));
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_finish"}, 32'(finish), 0);
    checkOutput({name, "_wen"}, 32'(mem.wen), 0);
    checkOutput({name, "_owner"}, 32'(mem.ksa_mem_handler), 0);
    checkOutput({name, "_memsel"}, 32'(mem.memory_sel), 0);
  endtask

  // Runs one start request; stops at finish, at abortAt, or at the cycle budget.
  task automatic applyStimulus(input logic [23:0] key, input int abortAt,
                               input bit checkFill, output int edges);
    int n;
    bit done;
    secret_key = key;
    expQ.delete();
    runModel(key, 256, 1'b1);
    writeCount = 0;
    start_sig  = 1'b1;
    n = 0;
    done = 1'b0;
    edges = -1;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checkOutput("start_owner", 32'(mem.ksa_mem_handler), 1);
        checkOutput("start_memsel", 32'(mem.memory_sel), 1);
      end
      if (checkFill && n == 258) begin
        for (int k = 0; k < 256; k++) checkOutput("init_fill", 32'(ram[k]), k);
      end
      if (n == abortAt) begin
        abort     = 1'b1;
        start_sig = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checkIdleOutputs("after_abort");
        checkOutput("writes_left_at_abort", expQ.size(), 312);
        done = 1'b1;
      end else if (finish) begin
        edges = n - 1;
        done  = 1'b1;
        checkOutput("done_owner", 32'(mem.ksa_mem_handler), 0);
        checkOutput("done_memsel", 32'(mem.memory_sel), 0);
      end
    end
    if (!done) checkOutput("finish_timeout", 0, 1);
  endtask

  initial begin
    int edges;
    reset_n    = 1'b0;
    start_sig  = 1'b0;
    abort      = 1'b0;
    secret_key = '0;

    // Reference model pinned against hand-worked first iterations.
    runModel(24'h000000, 4, 1'b0);
    checkOutput("model0_s0", 32'(modelS[0]), 0);
    checkOutput("model0_s2", 32'(modelS[2]), 3);
    checkOutput("model0_s3", 32'(modelS[3]), 5);
    checkOutput("model0_s5", 32'(modelS[5]), 2);
    runModel(24'h00033C, 4, 1'b0);
    checkOutput("modelg_s1", 32'(modelS[1]), 4);
    checkOutput("modelg_s2", 32'(modelS[2]), 8'h42);
    checkOutput("modelg_s3", 32'(modelS[3]), 8'h45);
    checkOutput("modelg_s4", 32'(modelS[4]), 1);
    checkOutput("modelg_s66", 32'(modelS[66]), 2);
    checkOutput("modelg_s69", 32'(modelS[69]), 3);
    expQ.delete();

    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset_n = 1'b1;

    // Reset in the middle of the init fill.
    secret_key = '0;
    runModel(24'h000000, 256, 1'b1);
    start_sig = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("midinit_wen", 32'(mem.wen), 1);
    reset_n = 1'b0;
    #1;
    checkIdleOutputs("midinit_reset");
    checkOutput("midinit_reset_addr", 32'(mem.address), 0);
    checkOutput("midinit_reset_data", 32'(mem.data), 0);
    start_sig = 1'b0;
    expQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkIdleOutputs("idle_after_reset");
    end

    // Zero key: init fill, i==j first swap, full result.
    applyStimulus(24'h000000, 0, 1'b1, edges);
    checkOutput("latency_zero_key", edges, 2817);
    checkOutput("ieqj_wr_i_addr", 32'(logA[256]), 0);
    checkOutput("ieqj_wr_i_data", 32'(logD[256]), 0);
    checkOutput("ieqj_wr_j_addr", 32'(logA[257]), 0);
    checkOutput("ieqj_wr_j_data", 32'(logD[257]), 0);
    checkOutput("ieqj_s0", 32'(ram[0]), 0);
    checkRam("final_ram_zero_key");
    start_sig = 1'b0;
    @(negedge clk);
    checkIdleOutputs("idle_after_zero_key");

    // Golden key.
    applyStimulus(24'h00033C, 0, 1'b0, edges);
    checkOutput("latency_golden", edges, 2817);
    checkRam("final_ram_golden");
    start_sig = 1'b0;
    @(negedge clk);

    // Abort in READ_J of iteration 100, then a clean restart.
    applyStimulus(24'h00033C, 1263, 1'b0, edges);
    repeat (3) begin
      @(negedge clk);
      checkIdleOutputs("idle_after_abort");
    end
    applyStimulus(24'h00033C, 0, 1'b0, edges);
    checkOutput("latency_restart", edges, 2817);
    checkRam("final_ram_restart");

    // DONE holds while start stays high, releases one cycle after it drops.
    repeat (20) begin
      @(negedge clk);
      checkOutput("done_hold_finish", 32'(finish), 1);
    end
    start_sig = 1'b0;
    @(negedge clk);
    checkIdleOutputs("done_release");
    @(negedge clk);
    checkIdleOutputs("idle_stays");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
